// File: rtl/pool_nl_pkg.sv
// Shared types and sizing for the pooling/non-linear adder-tree controller.
package pool_nl_pkg;

    localparam int unsigned N_PE     = 32;
    localparam int unsigned WID      = 16;
    localparam int unsigned TREE_LAT = $clog2(N_PE);
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } adder_ctrl_state_e;

endpackage

// File: rtl/adder_tree_ctrl_if.sv
// Job config, PE-array input, tree control and result port of the adder-tree controller.
interface adder_tree_ctrl_if;
    import pool_nl_pkg::*;

    logic             cfg_start;
    logic [CNT_W-1:0] cfg_num_vec;
    logic [CNT_W-1:0] cfg_num_accum;
    logic [N_PE-1:0]  cfg_pe_mask;
    logic             in_valid;
    logic             in_ready;
    logic             adder_enable;
    logic [N_PE-1:0]  mac_enable;
    logic [WID-1:0]   tree_sum;
    logic             out_valid;
    logic [WID-1:0]   out_data;
    logic             out_ready;
    logic             busy;
    logic             done;

    // Controller side
    modport master (
        input  cfg_start, cfg_num_vec, cfg_num_accum, cfg_pe_mask,
        input  in_valid, tree_sum, out_ready,
        output in_ready, adder_enable, mac_enable, out_valid, out_data, busy, done
    );

    // PE array / tree / downstream side
    modport slave (
        output cfg_start, cfg_num_vec, cfg_num_accum, cfg_pe_mask,
        output in_valid, tree_sum, out_ready,
        input  in_ready, adder_enable, mac_enable, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/adder_tree_ctrl_token_pipe.sv
// Valid-token shift register mirroring the stall-together adder tree stages.
module token_pipe
    import pool_nl_pkg::*;
#(
    parameter int unsigned DEPTH = TREE_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [DEPTH-1:0] v
);

    // v[0] is stage 1, v[DEPTH-1] is the tree's final stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else if (clr) begin
            v <= '0;
        end else if (en) begin
            v <= {v[DEPTH-2:0], din};
        end
    end

endmodule

// File: rtl/adder_tree_ctrl.sv
// Sequences vectors into the pipelined adder tree and accumulates tree sums into results.
module adder_tree_ctrl
    import pool_nl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    adder_tree_ctrl_if.master bus
);

    adder_ctrl_state_e   state;
    logic [CNT_W-1:0]    num_vec_q;
    logic [CNT_W-1:0]    num_accum_q;
    logic [N_PE-1:0]     mask_q;
    logic [CNT_W-1:0]    issued;
    logic [CNT_W-1:0]    acc_cnt;
    logic [CNT_W-1:0]    res_cnt;
    logic [WID-1:0]      acc;
    logic [WID-1:0]      out_data_q;
    logic                out_valid_q;
    logic [TREE_LAT-1:0] vpipe;

    logic             start;
    logic             active;
    logic             advance;
    logic             can_issue;
    logic             accept;
    logic             token;
    logic             emit;
    logic [WID-1:0]   sum;

    // Whole tree advances together; it freezes only while a result is held
    assign start     = (state == IDLE) && bus.cfg_start;
    assign active    = (state == RUN) || (state == DRAIN);
    assign advance   = active && (!out_valid_q || bus.out_ready);
    assign can_issue = (state == RUN) && advance && (issued < num_vec_q);
    assign accept    = bus.in_valid && can_issue;
    assign token     = vpipe[TREE_LAT-1] && advance;
    assign sum       = WID'((acc_cnt == '0 ? '0 : acc) + bus.tree_sum);
    assign emit      = token && ((acc_cnt == num_accum_q - CNT_W'(1)) ||
                                 (res_cnt == num_vec_q - CNT_W'(1)));

    assign bus.in_ready     = can_issue;
    assign bus.adder_enable = advance;
    assign bus.mac_enable   = active ? mask_q : '0;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);

    token_pipe #(.DEPTH(TREE_LAT)) u_token_pipe (
        .clk (clk),
        .rst (rst),
        .en  (advance),
        .clr (start),
        .din (accept),
        .v   (vpipe)
    );

    // Job FSM and latched configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num_vec_q   <= '0;
            num_accum_q <= '0;
            mask_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cfg_start) begin
                        num_vec_q   <= bus.cfg_num_vec;
                        num_accum_q <= (bus.cfg_num_accum == '0) ? CNT_W'(1) : bus.cfg_num_accum;
                        mask_q      <= bus.cfg_pe_mask;
                        state       <= (bus.cfg_num_vec == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept && (issued == num_vec_q - CNT_W'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((vpipe == '0) && !out_valid_q) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Issue/accumulate counters and the partial-sum register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued  <= '0;
            acc_cnt <= '0;
            res_cnt <= '0;
            acc     <= '0;
        end else if (start) begin
            issued  <= '0;
            acc_cnt <= '0;
            res_cnt <= '0;
            acc     <= '0;
        end else begin
            if (accept) begin
                issued <= issued + CNT_W'(1);
            end
            if (token) begin
                res_cnt <= res_cnt + CNT_W'(1);
                if (emit) begin
                    acc_cnt <= '0;
                end else begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                    acc     <= sum;
                end
            end
        end
    end

    // Result register; a reload wins over the downstream handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sum;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_tree_ctrl.sv
// Directed bench for adder_tree_ctrl with a behavioural TREE_LAT-stage adder tree.
module tb_adder_tree_ctrl;
    import pool_nl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adder_tree_ctrl_if bus ();

    adder_tree_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [WID-1:0] lane_val [N_PE];
    logic [WID-1:0] stage    [TREE_LAT];
    logic [WID-1:0] masked_sum;

    // Tree model: masked lane sum enters stage 1, all stages shift on adder_enable
    always_comb begin
        masked_sum = '0;
        for (int i = 0; i < N_PE; i++) begin
            if (bus.mac_enable[i]) masked_sum = WID'(masked_sum + lane_val[i]);
        end
    end

    always @(posedge clk) begin
        if (bus.adder_enable) begin
            stage[0] <= masked_sum;
            for (int k = 1; k < TREE_LAT; k++) stage[k] <= stage[k-1];
        end
    end

    assign bus.tree_sum = stage[TREE_LAT-1];

    logic [WID-1:0] res_q [$];
    logic [WID-1:0] exp_q [$];
    int done_cnt;
    int lat;
    int ov_cyc;
    int viol;
    int stall_cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_lanes(input logic [WID-1:0] lo, input logic [WID-1:0] hi, input bit ramp);
        for (int i = 0; i < N_PE; i++) begin
            if (ramp) lane_val[i] = WID'(i + 1);
            else      lane_val[i] = (i < N_PE/2) ? lo : hi;
        end
    endtask

    task automatic check_res(input string tag);
        chk({tag, "_count"}, 32'(res_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
            chk($sformatf("%s_res%0d", tag, i), 32'(res_q[i]), 32'(exp_q[i]));
        end
    endtask

    // Runs one job from IDLE until a few cycles after done, recording results
    task automatic run_job(input int nv, input int na, input logic [31:0] mask,
                           input bit rnd_valid, input int stall_len, input bit poke);
        int  first_acc;
        int  stall_left;
        bit  stall_started;
        bit  prev_hold;
        logic [WID-1:0] prev_data;
        int  post;
        bit  done_seen;

        res_q.delete();
        done_cnt = 0; lat = -1; ov_cyc = 0; viol = 0; stall_cyc = 0;
        first_acc = -1; stall_left = 0; stall_started = 0;
        prev_hold = 0; prev_data = '0; post = 0; done_seen = 0;

        @(negedge clk);
        bus.cfg_num_vec   = CNT_W'(nv);
        bus.cfg_num_accum = CNT_W'(na);
        bus.cfg_pe_mask   = mask;
        bus.cfg_start     = 1'b1;
        bus.in_valid      = 1'b0;
        bus.out_ready     = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            bus.in_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_len > 0 && !stall_started && bus.out_valid) begin
                stall_started = 1;
                stall_left    = stall_len;
            end
            bus.out_ready = (stall_left == 0);
            if (poke && cyc == 3) begin
                bus.cfg_start   = 1'b1;
                bus.cfg_num_vec = CNT_W'(1);
            end else begin
                bus.cfg_start = 1'b0;
            end
            #1;
            if (prev_hold && (!bus.out_valid || bus.out_data != prev_data)) viol++;
            if (!bus.out_ready) begin
                stall_cyc++;
                if (bus.out_valid && (bus.adder_enable || bus.in_ready)) viol++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            if (bus.in_valid && bus.in_ready && first_acc < 0) first_acc = cyc;
            if (bus.out_valid && lat < 0 && first_acc >= 0) lat = cyc - first_acc;
            if (bus.out_valid) ov_cyc++;
            if (bus.out_valid && bus.out_ready) res_q.push_back(bus.out_data);
            if (bus.done) begin
                done_cnt++;
                done_seen = 1;
            end
            if (stall_left > 0) stall_left--;
            if (done_seen) post++;
            if (post > 3) break;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.cfg_start = 1'b0;
        if (!done_seen) chk("job_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int n_acc;
        int bad;

        rst = 1'b1;
        bus.cfg_start = 1'b0; bus.cfg_num_vec = '0; bus.cfg_num_accum = '0;
        bus.cfg_pe_mask = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        set_lanes(16'd1, 16'd1, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid",    32'(bus.out_valid),    32'(0));
        chk("rst_out_data",     32'(bus.out_data),     32'(0));
        chk("rst_in_ready",     32'(bus.in_ready),     32'(0));
        chk("rst_adder_enable", 32'(bus.adder_enable), 32'(0));
        chk("rst_mac_enable",   32'(bus.mac_enable),   32'(0));
        chk("rst_busy",         32'(bus.busy),         32'(0));
        chk("rst_done",         32'(bus.done),         32'(0));
        @(negedge clk);
        rst = 1'b0;

        // All lanes 1, one sum per result
        run_job(4, 1, 32'hFFFF_FFFF, 0, 0, 0);
        exp_q = {16'd32, 16'd32, 16'd32, 16'd32};
        check_res("A");
        chk("A_latency", 32'(lat), 32'(6));
        chk("A_done", 32'(done_cnt), 32'(1));

        // Groups of three sums
        run_job(6, 3, 32'hFFFF_FFFF, 0, 0, 0);
        exp_q = {16'd96, 16'd96};
        check_res("B");
        chk("B_ov_cycles", 32'(ov_cyc), 32'(2));
        chk("B_done", 32'(done_cnt), 32'(1));

        // Partial final group, with a start pulse mid-job that must be ignored
        run_job(5, 2, 32'hFFFF_FFFF, 0, 0, 1);
        exp_q = {16'd64, 16'd64, 16'd32};
        check_res("C");
        chk("C_done", 32'(done_cnt), 32'(1));

        // Upper half masked off while carrying nonzero data
        set_lanes(16'd2, 16'd7, 0);
        run_job(3, 1, 32'h0000_FFFF, 0, 0, 0);
        exp_q = {16'd32, 16'd32, 16'd32};
        check_res("D");

        // All lanes masked
        set_lanes(16'd5, 16'd5, 0);
        run_job(2, 1, 32'h0000_0000, 0, 0, 0);
        exp_q = {16'd0, 16'd0};
        check_res("Z");

        // Wrap-around accumulation: 32*0xFFFF -> 0xFFE0, two of them -> 0xFFC0
        set_lanes(16'hFFFF, 16'hFFFF, 0);
        run_job(2, 2, 32'hFFFF_FFFF, 0, 0, 0);
        exp_q = {16'hFFC0};
        check_res("W");

        // Downstream stall with random bubbles: lanes 1..32 sum to 528
        set_lanes(16'd0, 16'd0, 1);
        run_job(8, 2, 32'hFFFF_FFFF, 1, 10, 0);
        exp_q = {16'd1056, 16'd1056, 16'd1056, 16'd1056};
        check_res("E");
        chk("E_stall_cycles", 32'(stall_cyc), 32'(10));
        chk("E_stall_viol", 32'(viol), 32'(0));
        chk("E_done", 32'(done_cnt), 32'(1));

        // Empty job and zero accumulation depth
        run_job(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        exp_q = {};
        check_res("N0");
        chk("N0_done", 32'(done_cnt), 32'(1));
        set_lanes(16'd1, 16'd1, 0);
        run_job(2, 0, 32'hFFFF_FFFF, 0, 0, 0);
        exp_q = {16'd32, 16'd32};
        check_res("A0");

        // Reset while draining
        @(negedge clk);
        bus.cfg_num_vec = CNT_W'(2); bus.cfg_num_accum = CNT_W'(1);
        bus.cfg_pe_mask = 32'hFFFF_FFFF; bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 50 && n_acc < 2; c++) begin
            #1;
            if (bus.in_valid && bus.in_ready) n_acc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        chk("R_in_drain_busy", 32'(bus.busy), 32'(1));
        chk("R_in_drain_ready", 32'(bus.in_ready), 32'(0));
        rst = 1'b1;
        #1;
        chk("R_out_valid",    32'(bus.out_valid),    32'(0));
        chk("R_adder_enable", 32'(bus.adder_enable), 32'(0));
        chk("R_mac_enable",   32'(bus.mac_enable),   32'(0));
        chk("R_busy",         32'(bus.busy),         32'(0));
        chk("R_done",         32'(bus.done),         32'(0));
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.out_valid || bus.busy) bad++;
        end
        chk("R_quiet_after", 32'(bad), 32'(0));
        run_job(3, 1, 32'hFFFF_FFFF, 0, 0, 0);
        exp_q = {16'd32, 16'd32, 16'd32};
        check_res("R_new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_tree_ctrl.md
Name: adder_tree_ctrl

Overview:
Sequencing controller for the pooling/non-linear block's pipelined adder tree. It accepts a job (vector count, accumulation depth, PE mask) and streams vectors from the PE array into the tree. It drives adder_enable and mac_enable, and tracks valid tokens through the tree's stall-together pipeline. It accumulates successive tree sums into one result and hands results downstream on a valid/ready port.

Parameters:
N_PE, `N_PE (32), number of MAC lanes feeding the tree
WID, `WID_PE_BITS (16), datapath width of tree sum and result
TREE_LAT, 5, tree register stages (log2 N_PE)
CNT_W, 16, width of job counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_start  in  1  start pulse; sampled only in IDLE
cfg_num_vec  in  CNT_W  vectors in job
cfg_num_accum  in  CNT_W  tree sums summed per result; 0 treated as 1
cfg_pe_mask  in  N_PE  active lanes
in_valid  in  1  PE array has a vector on the tree input
in_ready  out  1  vector consumed this cycle
adder_enable  out  1  advance all tree stages
mac_enable  out  N_PE  lane mask to tree
tree_sum  in  WID  tree final-stage output
out_valid  out  1  result available
out_data  out  WID  accumulated result
out_ready  in  1  downstream accepts
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values: all outputs 0; FSM IDLE; counters, valid pipe and accumulator 0.
- FSM states:
  - IDLE: on cfg_start, latch cfg_*. If num_vec==0, go to DONE; else go to RUN.
  - RUN: stay while issued < num_vec. Go to DRAIN in the cycle the last vector is accepted.
  - DRAIN: go to DONE when the valid pipe is all 0 and out_valid==0.
  - DONE: done=1 for one cycle, then IDLE.
- advance = (state RUN or DRAIN) && (!out_valid || out_ready). adder_enable = advance.
  - Whole tree stalls while the output register is held; there is no partial stall.
- in_ready = state==RUN && advance && issued<num_vec.
  - Accept = in_valid && in_ready; issued increments on accept.
- Valid pipe v[1..TREE_LAT] (shift register):
  - On advance: v[1] <= accept; v[k] <= v[k-1].
  - Holds when !advance.
  - Bubbles (in_valid=0) still clock the tree but carry v=0.
- tree_sum is valid in any cycle where v[TREE_LAT]==1 and advance==1. That is the cycle the token leaves stage TREE_LAT; latency from accept is TREE_LAT advances.
- Accumulation, on a consumed token:
  - sum = (acc_cnt==0 ? 0 : acc) + tree_sum, truncated to WID bits (wrap, no saturation).
  - Increment acc_cnt and res_cnt.
- Emit when acc_cnt==num_accum-1 OR res_cnt==num_vec-1 (partial flush of the final group):
  - out_data <= sum; out_valid <= 1; acc_cnt <= 0.
  - Otherwise acc <= sum.
- Output register:
  - out_valid clears on out_valid && out_ready unless reloaded in the same cycle.
  - Back-to-back emission is allowed because advance is true when out_ready==1.
  - out_data is stable while out_valid && !out_ready.
- mac_enable = latched mask while busy; 0 in IDLE/DONE.
- Boundary conditions:
  - cfg_start outside IDLE is ignored.
  - Mask all-zero: results are 0 and counts are unchanged.
  - Counters never wrap within a job (num_vec < 2^CNT_W).
  - Reset mid-job: immediate return to IDLE, out_valid drops, no done pulse. Stale tree contents are harmless because the valid pipe is cleared.
  - out_ready held low: pipeline freezes with tokens intact and no token is lost or duplicated.
  - Simultaneous last accept and final emission: handled by the normal RUN->DRAIN path.

Decomposition:
- Shared package pool_nl_pkg holds:
  - the adder_ctrl_state_e enum (IDLE/RUN/DRAIN/DONE)
  - TREE_LAT, derived as $clog2(`N_PE)
  - the counter width
- One natural sub-module: token_pipe, a TREE_LAT-deep valid shift register with enable and clear.
- The accumulator and FSM stay in the top module.

Test Plan:
- Mask all ones, every lane=1, num_vec=4, num_accum=1, out_ready=1 -> four results of 32. First out_valid 6 cycles after first accept; done 1 cycle after last.
- Lanes=1, num_vec=6, num_accum=3 -> two results of 96; out_valid never high between group boundaries.
- num_vec=5, num_accum=2 -> results 64, 64, 32 (partial flush); done once.
- Mask 0x0000FFFF, lanes=2 -> each sum 32; masked lanes ignored even with nonzero data.
- out_ready low 10 cycles mid-job, in_valid random -> adder_enable and in_ready low while stalled; result sequence identical to the unstalled run.
- Assert rst during DRAIN -> all outputs 0 next cycle, no done. A new job afterwards produces correct results.
